// File: rtl/dvi_video_out_pkg.sv
// Shared definitions for dvi_video_out: XGA timing defaults, IDF=3 half-word
// field layout, FSM encoding and colour-bar lookup (used with DVI_TEST_PATTERN_EN).
package dvi_video_out_pkg;

  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;
  localparam int DEF_V_ACTIVE = 768;
  localparam bit DEF_SYNC_POL = 1'b0;

  // Bit positions of the colour fields inside the two 12-bit IDF=3 half words
  localparam int IDF_B_R_LSB = 6;
  localparam int IDF_B_G_LSB = 4;
  localparam int IDF_A_G_LSB = 9;
  localparam int IDF_A_B_LSB = 4;

  typedef enum logic {
    ST_RESYNC = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  function automatic logic [11:0] idf3_word_b(input logic [14:0] px);
    logic [11:0] w;
    w = '0;
    w[IDF_B_R_LSB +: 5] = px[14:10];
    w[IDF_B_G_LSB +: 2] = px[9:8];
    return w;
  endfunction

  function automatic logic [11:0] idf3_word_a(input logic [14:0] px);
    logic [11:0] w;
    w = '0;
    w[IDF_A_G_LSB +: 3] = px[7:5];
    w[IDF_A_B_LSB +: 5] = px[4:0];
    return w;
  endfunction

  // White, yellow, cyan, green, magenta, red, blue, black as {R,G,B} enables
  function automatic logic [14:0] bar_color(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return {{5{rgb[2]}}, {5{rgb[1]}}, {5{rgb[0]}}};
  endfunction

endpackage

// File: rtl/dvi_video_out_raster_counter.sv
// Horizontal/vertical raster counters with region decode for dvi_video_out.
// DVI_TEST_PATTERN_EN adds the frame_start and colour-bar index outputs.
module dvi_video_out_raster_counter #(
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int H_ACTIVE = 1024,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 768
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       first_pixel,
  output logic       first_line,
  output logic       frame_end
`ifdef DVI_TEST_PATTERN_EN
  ,
  output logic       frame_start,
  output logic [2:0] bar
`endif
);

  localparam int H_TOTAL    = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL    = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW         = $clog2(H_TOTAL);
  localparam int VW         = $clog2(V_TOTAL);
  localparam int H_DE_START = H_SYNC + H_BP;
  localparam int H_DE_END   = H_DE_START + H_ACTIVE;
  localparam int V_DE_START = V_SYNC + V_BP;
  localparam int V_DE_END   = V_DE_START + V_ACTIVE;

  logic [HW-1:0] h_reg;
  logic [VW-1:0] v_reg;
  logic          h_last;
  logic          v_last;
  logic          v_active;

  assign h_last = (h_reg == HW'(H_TOTAL - 1));
  assign v_last = (v_reg == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (h_last) begin
      h_reg <= '0;
      v_reg <= v_last ? '0 : v_reg + VW'(1);
    end else begin
      h_reg <= h_reg + HW'(1);
    end
  end

  // hsync is only produced on active lines; blanking lines stay quiet
  assign v_active    = (v_reg >= VW'(V_DE_START)) && (v_reg < VW'(V_DE_END));
  assign vsync       = (v_reg < VW'(V_SYNC));
  assign hsync       = v_active && (h_reg < HW'(H_SYNC));
  assign de          = v_active && (h_reg >= HW'(H_DE_START)) && (h_reg < HW'(H_DE_END));
  assign first_pixel = (v_reg == VW'(V_DE_START)) && (h_reg == HW'(H_DE_START));
  assign first_line  = (v_reg == '0);
  assign frame_end   = v_last && h_last;

`ifdef DVI_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [HW-1:0] h_rel;
  assign frame_start = first_line && (h_reg == '0);
  assign h_rel       = h_reg - HW'(H_DE_START);
  assign bar         = 3'(h_rel / HW'(BAR_W));
`endif

endmodule

// File: rtl/dvi_video_out.sv
// DVI source stage ahead of a CH7301C: raster timing, RGB555 handshake, IDF=3 packing
// and underflow resync. Defining DVI_TEST_PATTERN_EN adds an 8-bar test pattern input.
module dvi_video_out
  import dvi_video_out_pkg::*;
#(
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] pixel_data,
  input  logic        pixel_sof,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [11:0] dvi_data_b,
  output logic [11:0] dvi_data_a,
  output logic        dvi_de,
  output logic        dvi_h,
  output logic        dvi_v,
  output logic        underflow,
  input  logic        underflow_clr
`ifdef DVI_TEST_PATTERN_EN
  ,
  input  logic        test_pattern
`endif
);

  logic        hsync, vsync, de, first_pixel, first_line, frame_end;
  state_t      state_reg, state_next;
  logic        primed_reg;
  logic        ready, set_uf, show_pixel, tp_active, shown;
  logic [14:0] px_sel;

`ifdef DVI_TEST_PATTERN_EN
  logic       frame_start;
  logic [2:0] bar;
  logic       tp_reg;
`endif

  dvi_video_out_raster_counter #(
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE)
  ) u_raster (
    .clk(clk),
    .rst(rst),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .first_pixel(first_pixel),
    .first_line(first_line),
    .frame_end(frame_end)
`ifdef DVI_TEST_PATTERN_EN
    ,
    .frame_start(frame_start),
    .bar(bar)
`endif
  );

`ifdef DVI_TEST_PATTERN_EN
  // test_pattern is only looked at on the very first cycle of a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              tp_reg <= 1'b0;
    else if (frame_start) tp_reg <= test_pattern;
  end
  assign tp_active = frame_start ? test_pattern : tp_reg;
  assign px_sel    = tp_active ? bar_color(bar) : pixel_data;
`else
  assign tp_active = 1'b0;
  assign px_sel    = pixel_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_RESYNC;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (tp_active) begin
      if (frame_end) state_next = ST_RESYNC;
    end else if (state_reg == ST_RUN) begin
      if (set_uf) state_next = ST_RESYNC;
    end else if (show_pixel) begin
      state_next = ST_RUN;
    end
  end

  // primed_reg keeps the line-0 discard path quiet while reset is applied
  always_comb begin
    ready      = 1'b0;
    set_uf     = 1'b0;
    show_pixel = 1'b0;
    if (!tp_active) begin
      if (state_reg == ST_RUN) begin
        ready = de;
        if (de && (!pixel_valid || (first_pixel && !pixel_sof))) set_uf = 1'b1;
        else if (de)                                              show_pixel = 1'b1;
      end else begin
        if (first_pixel)                    ready = pixel_sof;
        else if (first_line && primed_reg) ready = ~pixel_sof;
        show_pixel = first_pixel && pixel_valid && pixel_sof;
      end
    end
  end

  assign pixel_ready = ready;
  assign shown       = de && (tp_active || show_pixel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_reg <= 1'b0;
      dvi_de     <= 1'b0;
      dvi_h      <= ~SYNC_POL;
      dvi_v      <= ~SYNC_POL;
      dvi_data_b <= '0;
      dvi_data_a <= '0;
      underflow  <= 1'b0;
    end else begin
      primed_reg <= 1'b1;
      dvi_de     <= de;
      dvi_h      <= hsync ? SYNC_POL : ~SYNC_POL;
      dvi_v      <= vsync ? SYNC_POL : ~SYNC_POL;
      dvi_data_b <= shown ? idf3_word_b(px_sel) : '0;
      dvi_data_a <= shown ? idf3_word_a(px_sel) : '0;
      if (set_uf)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

endmodule
